// File: rtl/scan_response_reader_pkg.sv
// Shared types, constants and MISR step function for the scan response reader.
package scan_reader_pkg;

    localparam int unsigned SIG_W = 16;
    localparam logic [SIG_W-1:0] DEFAULT_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        PRESENT
    } rd_state_t;

    // One MISR step: shift left, fold in POLY when the MSB falls off, xor the data word.
    function automatic logic [SIG_W-1:0] misr_next(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] poly,
        input logic [SIG_W-1:0] din
    );
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? poly : '0) ^ din;
    endfunction

endpackage

// File: rtl/scan_response_reader_if.sv
// Handshake and scan-chain signals of the scan response reader.
interface scan_response_reader_if
    import scan_reader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 8
);
    logic                 start;
    logic                 capture_en;
    logic                 scan_en;
    logic                 scan_out;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;
    logic                 sig_clr;
    logic [SIG_W-1:0]     sig;

    modport master (
        input  start, scan_out, resp_ready, sig_clr,
        output capture_en, scan_en, busy, resp_valid, resp_data, sig
    );

    modport slave (
        output start, scan_out, resp_ready, sig_clr,
        input  capture_en, scan_en, busy, resp_valid, resp_data, sig
    );
endinterface

// File: rtl/scan_response_reader_sig_misr.sv
// 16-bit response signature register; reset and clear take priority over update.
module sig_misr
    import scan_reader_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (upd) begin
            sig_d = misr_next(sig_q, POLY, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/scan_response_reader.sv
// Scan-chain unload controller: capture, serial shift-in, parallel present, MISR fold.
module scan_response_reader
    import scan_reader_pkg::*;
#(
    parameter int unsigned      CHAIN_LEN = 8,
    parameter logic [SIG_W-1:0] POLY      = DEFAULT_POLY
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    scan_response_reader_if.master bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    rd_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
    logic [CHAIN_LEN-1:0] resp_data_q, resp_data_d;
    logic [CHAIN_LEN-1:0] shifted;
    logic                 capture_en_q, capture_en_d;
    logic                 scan_en_q, scan_en_d;
    logic                 busy_q, busy_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 misr_upd;

    always_comb begin
        // Right shift with the tail bit entering at the top, so the first sample ends at bit 0.
        shifted                = sreg_q >> 1;
        shifted[CHAIN_LEN-1]   = bus.scan_out;

        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        resp_data_d = resp_data_q;
        misr_upd    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = PRESENT;
                    resp_data_d = shifted;
                    misr_upd    = 1'b1;
                end
            end
            PRESENT: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        capture_en_d = (state_d == CAPTURE);
        scan_en_d    = (state_d == SHIFT);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            resp_data_q  <= '0;
            capture_en_q <= 1'b0;
            scan_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            resp_data_q  <= resp_data_d;
            capture_en_q <= capture_en_d;
            scan_en_q    <= scan_en_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    sig_misr #(
        .POLY (POLY)
    ) u_sig_misr (
        .clk (sys_clk),
        .rst (rst),
        .clr (bus.sig_clr),
        .upd (misr_upd),
        .din (SIG_W'(shifted)),
        .sig (bus.sig)
    );

    assign bus.capture_en = capture_en_q;
    assign bus.scan_en    = scan_en_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_scan_response_reader.sv
// Directed bench for scan_response_reader with a response scoreboard and signature model.
module tb_scan_response_reader;
    import scan_reader_pkg::*;

    localparam int unsigned CL = 8;

    logic sys_clk;
    logic rst;

    scan_response_reader_if #(.CHAIN_LEN(CL)) bus ();

    scan_response_reader #(
        .CHAIN_LEN (CL),
        .POLY      (16'h1021)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.master)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [CL-1:0] sb[$];
    logic [15:0]   sig_exp = '0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [CL-1:0] w);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ 16'h1021;
        return r ^ {8'h00, w};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full unload of word; hold = cycles with resp_ready low, clr = sig_clr on the update edge.
    task automatic unload(input logic [CL-1:0] word, input int unsigned hold,
                          input bit clr, input bit poke);
        logic [CL-1:0] exp_w;
        bus.resp_ready = (hold == 0);
        bus.start = 1'b1;
        sb.push_back(word);
        sig_exp = clr ? 16'h0000 : model_misr(sig_exp, word);
        tick();
        bus.start = 1'b0;
        chk("capture_en_c1", bus.capture_en, 1);
        chk("scan_en_c1", bus.scan_en, 0);
        chk("busy_c1", bus.busy, 1);
        tick();
        for (int i = 0; i < CL; i++) begin
            chk("scan_en_shift", bus.scan_en, 1);
            chk("capture_en_shift", bus.capture_en, 0);
            chk("resp_valid_shift", bus.resp_valid, 0);
            bus.scan_out = word[i];
            if (i == CL - 1) bus.sig_clr = clr;
            tick();
        end
        bus.sig_clr = 1'b0;
        chk("resp_valid_rise", bus.resp_valid, 1);
        chk("scan_en_present", bus.scan_en, 0);
        chk("sig_update", bus.sig, sig_exp);
        for (int unsigned k = 0; k < hold; k++) begin
            bus.start = poke;
            chk("resp_valid_hold", bus.resp_valid, 1);
            chk("resp_data_hold", bus.resp_data, sb[0]);
            tick();
        end
        bus.start = 1'b0;
        bus.resp_ready = 1'b1;
        chk("resp_valid_hs", bus.resp_valid, 1);
        exp_w = sb.pop_front();
        chk("resp_data", bus.resp_data, exp_w);
        tick();
        bus.resp_ready = 1'b0;
        chk("resp_valid_drop", bus.resp_valid, 0);
        chk("busy_drop", bus.busy, 0);
        tick();
        chk("busy_idle", bus.busy, 0);
        chk("sig_stable", bus.sig, sig_exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b1;
        bus.scan_out = 1'b0;
        bus.resp_ready = 1'b0;
        bus.sig_clr = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_capture_en", bus.capture_en, 0);
        chk("rst_scan_en", bus.scan_en, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_sig", bus.sig, 0);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);

        unload(8'h4D, 0, 1'b0, 1'b0);
        chk("sig_first", bus.sig, 16'h004D);
        unload(8'hFF, 5, 1'b0, 1'b1);
        chk("sig_second", bus.sig, 16'h0065);
        unload(8'h3C, 0, 1'b1, 1'b0);
        chk("sig_clr_wins", bus.sig, 16'h0000);

        // Abort during the fourth SHIFT cycle.
        unload(8'h11, 0, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.scan_out = 1'b1;
            tick();
        end
        chk("abort_scan_en_before", bus.scan_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sig_exp = '0;
        chk("abort_scan_en", bus.scan_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_sig", bus.sig, 0);
        tick();
        chk("abort_idle", bus.busy, 0);
        unload(8'hA5, 0, 1'b0, 1'b0);

        bus.sig_clr = 1'b1;
        tick();
        bus.sig_clr = 1'b0;
        sig_exp = '0;
        chk("sig_clr_idle", bus.sig, 0);
        unload(8'h80, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) unload(8'h00, 0, 1'b0, 1'b0);
        chk("sig_preload", bus.sig, 16'h8000);
        unload(8'h00, 0, 1'b0, 1'b0);
        chk("sig_wrap", bus.sig, 16'h1021);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
